seg_scroller: RTL and testbench

- Parametrised marquee scroller for an N-digit 7-segment bank.
- Holds a ring of N symbol codes and rotates it by one digit per scroll tick.
- Scroll period comes from a programmable divider; rate and direction are runtime-adjustable.
- Sits between board buttons/switches and the HEX outputs; each digit is driven through its own symbol-to-segment decoder.

---
 rtl/seg_scroller_pkg.sv | 23 ++
 rtl/seg_decoder.sv | 30 +++
 rtl/seg_scroller.sv | 197 +++++++++++++++++++
 tb/tb_seg_scroller.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scroller_pkg.sv
// seg_scroller_pkg: shared constants for the 7-segment marquee scroller.
//   - Symbol codes that have a fixed meaning (blank, all segments on).
//   - Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g.
//   - Scroll direction encodings as seen on the dir input.
package seg_scroller_pkg;

  localparam int unsigned SYM_BLANK = 0;
  localparam int unsigned SYM_FULL  = 7;

  // Active-low: a 0 bit lights the segment. Bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_FULL  = 7'b0000000;
  localparam logic [6:0] SEG_A     = 7'b1111110;
  localparam logic [6:0] SEG_G     = 7'b0111111;
  localparam logic [6:0] SEG_D     = 7'b1110111;
  localparam logic [6:0] SEG_EF    = 7'b1001111;
  localparam logic [6:0] SEG_BC    = 7'b1111001;
  localparam logic [6:0] SEG_ADG   = 7'b0110110;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: combinational symbol-code to 7-segment decoder, one per digit.
// Ports:
//   sym_i  SYM_W-bit symbol code
//   seg_o  active-low segments, bit 0 = a ... bit 6 = g
// Codes 0..7 have fixed glyphs; any wider code decodes to blank.
module seg_decoder
  import seg_scroller_pkg::*;
#(
  parameter int unsigned SYM_W = 3
) (
  input  logic [SYM_W-1:0] sym_i,
  output logic [6:0]       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (32'(sym_i))
      SYM_BLANK: seg_o = SEG_BLANK;
      32'd1:     seg_o = SEG_A;
      32'd2:     seg_o = SEG_G;
      32'd3:     seg_o = SEG_D;
      32'd4:     seg_o = SEG_EF;
      32'd5:     seg_o = SEG_BC;
      32'd6:     seg_o = SEG_ADG;
      SYM_FULL:  seg_o = SEG_FULL;
      default:   seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scroller.sv
// seg_scroller: marquee scroller for an N_DIGITS 7-segment bank.
// A ring of N_DIGITS symbol codes rotates one digit per divider tick; the
// divider limit is stepped by speed_up/speed_dn rising edges.
// Ports:
//   CLOCK_50, reset      clock, synchronous active-high reset
//   speed_up, speed_dn   level buttons, one limit step per rising edge
//   dir, run             scroll direction (0 = left) and enable, sampled on tick
//   load, load_pattern   strobe + pattern to load into the ring (beats tick)
//   pattern_out          registered ring contents, digit i = [i*SYM_W +: SYM_W]
//   tick                 one-cycle pulse on each divider wrap
//   div_limit            current divider limit
//   hex_out              active-low segments, digit i = [i*7 +: 7]
// Build option: define SEG_SCROLLER_DEBOUNCE_EN to debounce speed_up, speed_dn
// and load over DEB_CYCLES stable cycles before they are used.
module seg_scroller
  import seg_scroller_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned SYM_W       = 3,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DIV_DEFAULT = 49999999,
  parameter int unsigned DIV_STEP    = 5000000,
  parameter int unsigned DIV_MIN     = 4999999,
  parameter int unsigned DIV_MAX     = 99999999,
  parameter int unsigned DEB_CYCLES  = 500000
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      speed_up,
  input  logic                      speed_dn,
  input  logic                      dir,
  input  logic                      run,
  input  logic                      load,
  input  logic [N_DIGITS*SYM_W-1:0] load_pattern,
  output logic [N_DIGITS*SYM_W-1:0] pattern_out,
  output logic                      tick,
  output logic [CNT_W-1:0]          div_limit,
  output logic [N_DIGITS*7-1:0]     hex_out
);

  localparam int unsigned PAT_W = N_DIGITS * SYM_W;

  localparam logic [CNT_W:0]   STEP_X  = (CNT_W + 1)'(DIV_STEP);
  localparam logic [CNT_W:0]   MIN_X   = (CNT_W + 1)'(DIV_MIN);
  localparam logic [CNT_W:0]   MAX_X   = (CNT_W + 1)'(DIV_MAX);
  localparam logic [CNT_W-1:0] DEF_L   = CNT_W'(DIV_DEFAULT);
  localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(SYM_FULL);

  if (N_DIGITS < 2) begin : g_bad_digits
    $error("seg_scroller: N_DIGITS must be at least 2");
  end
  if (DIV_MIN > DIV_DEFAULT || DIV_DEFAULT > DIV_MAX) begin : g_bad_order
    $error("seg_scroller: need DIV_MIN <= DIV_DEFAULT <= DIV_MAX");
  end
  if (64'(DIV_MAX) >= (64'd1 << CNT_W)) begin : g_bad_width
    $error("seg_scroller: DIV_MAX does not fit in CNT_W bits");
  end
  // A zero-length stability window has no meaning for the debouncer.
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("seg_scroller: DEB_CYCLES must be at least 1");
  end

  logic up_lvl, dn_lvl, load_evt;

`ifdef SEG_SCROLLER_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

  // Index 0 = speed_up, 1 = speed_dn, 2 = load.
  logic [2:0]       deb_raw;
  logic [2:0]       deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q [3];
  logic [DEB_W-1:0] deb_cnt_d [3];
  logic             load_prev_q, load_prev_d;

  assign deb_raw = {load, speed_dn, speed_up};

  // Count consecutive cycles the raw input disagrees with the debounced level;
  // any agreement restarts the window.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (deb_raw[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_d[i] = deb_raw[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
    load_prev_d = deb_q[2];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      deb_q       <= '0;
      load_prev_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      deb_q       <= deb_d;
      load_prev_q <= load_prev_d;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign up_lvl   = deb_q[0];
  assign dn_lvl   = deb_q[1];
  assign load_evt = deb_q[2] & ~load_prev_q;
`else
  assign up_lvl   = speed_up;
  assign dn_lvl   = speed_dn;
  assign load_evt = load;
`endif

  logic             up_prev_q, up_prev_d;
  logic             dn_prev_q, dn_prev_d;
  logic             up_edge, dn_edge;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W:0]   lim_ext, lim_sum;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             wrap;

  always_comb begin
    up_prev_d = up_lvl;
    dn_prev_d = dn_lvl;
    up_edge   = up_lvl & ~up_prev_q;
    dn_edge   = dn_lvl & ~dn_prev_q;

    // Limit arithmetic is done one bit wider so neither direction can wrap.
    lim_ext = {1'b0, limit_q};
    lim_sum = lim_ext + STEP_X;
    limit_d = limit_q;
    if (up_edge && !dn_edge) begin
      if (lim_ext >= MIN_X + STEP_X) begin
        limit_d = limit_q - CNT_W'(DIV_STEP);
      end else begin
        limit_d = CNT_W'(DIV_MIN);
      end
    end else if (dn_edge && !up_edge) begin
      if (lim_sum > MAX_X) begin
        limit_d = CNT_W'(DIV_MAX);
      end else begin
        limit_d = lim_sum[CNT_W-1:0];
      end
    end

    // >= so that a limit lowered under the running count wraps immediately.
    wrap  = (cnt_q >= limit_q);
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);

    pat_d = pat_q;
    if (load_evt) begin
      pat_d = load_pattern;
    end else if (wrap && run) begin
      if (dir == DIR_LEFT) begin
        pat_d = {pat_q[PAT_W-SYM_W-1:0], pat_q[PAT_W-1 -: SYM_W]};
      end else begin
        pat_d = {pat_q[SYM_W-1:0], pat_q[PAT_W-1:SYM_W]};
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q     <= '0;
      limit_q   <= DEF_L;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      pat_q     <= PAT_RST;
    end else begin
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      up_prev_q <= up_prev_d;
      dn_prev_q <= dn_prev_d;
      pat_q     <= pat_d;
    end
  end

  assign tick        = wrap & ~reset;
  assign div_limit   = limit_q;
  assign pattern_out = pat_q;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    seg_decoder #(
      .SYM_W (SYM_W)
    ) u_dec (
      .sym_i (pat_q[i*SYM_W +: SYM_W]),
      .seg_o (hex_out[i*7 +: 7])
    );
  end

endmodule

// File: tb/tb_seg_scroller.sv
// Self-checking bench for seg_scroller with a short divider (limit 9, step 2,
// range 3..15). Expected ring contents are queued when stimulus is applied and
// popped by a monitor on the cycle after each tick.
module tb_seg_scroller;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 3;
  localparam int unsigned PW = N * W;
  localparam logic [PW-1:0] PAT_RST = 24'h000007;

  logic            clk = 1'b0;
  logic            reset;
  logic            speed_up, speed_dn, dir, run, load;
  logic [PW-1:0]   load_pattern;
  logic [PW-1:0]   pattern_out;
  logic            tick;
  logic [26:0]     div_limit;
  logic [N*7-1:0]  hex_out;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] sb_exp;
  bit            sb_on = 1'b0;
  bit            pend  = 1'b0;

  seg_scroller #(
    .N_DIGITS    (8),
    .SYM_W       (3),
    .CNT_W       (27),
    .DIV_DEFAULT (9),
    .DIV_STEP    (2),
    .DIV_MIN     (3),
    .DIV_MAX     (15),
    .DEB_CYCLES  (4)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .speed_up     (speed_up),
    .speed_dn     (speed_dn),
    .dir          (dir),
    .run          (run),
    .load         (load),
    .load_pattern (load_pattern),
    .pattern_out  (pattern_out),
    .tick         (tick),
    .div_limit    (div_limit),
    .hex_out      (hex_out)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a tick seen now means the ring changes on the next edge.
  always @(posedge clk) begin
    #1;
    if (pend && exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      checks++;
      if (pattern_out !== sb_exp) begin
        errors++;
        $display("FAIL sb_pattern: got %h, required %h", pattern_out, sb_exp);
      end
    end
    pend = sb_on && (tick === 1'b1);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] seg_of(input int code);
    case (code)
      0:       return 7'b1111111;
      1:       return 7'b1111110;
      2:       return 7'b0111111;
      3:       return 7'b1110111;
      4:       return 7'b1001111;
      5:       return 7'b1111001;
      6:       return 7'b0110110;
      7:       return 7'b0000000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [PW-1:0] rot_left(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[((i + 1) % N) * W +: W] = p[i*W +: W];
    return r;
  endfunction

  task automatic tick_wait(input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      cyc = n + 1;
      if (tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    reset = 1'b1; speed_up = 1'b0; speed_dn = 1'b0;
    dir = 1'b0; run = 1'b1; load = 1'b0; load_pattern = '0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (pattern_out !== PAT_RST) begin
      errors++; $display("FAIL reset_pattern: got %h, required %h", pattern_out, PAT_RST);
    end
    checks++;
    if (div_limit !== 27'd9) begin
      errors++; $display("FAIL reset_limit: got %0d, required 9", div_limit);
    end
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick: got %b, required 0", tick);
    end
    for (int i = 0; i < N; i++) begin
      e = (i == 0) ? seg_of(7) : seg_of(0);
      checks++;
      if (hex_out[i*7 +: 7] !== e) begin
        errors++; $display("FAIL reset_hex%0d: got %b, required %b", i, hex_out[i*7 +: 7], e);
      end
    end
  endtask

  task automatic test_scroll_left();
    logic [PW-1:0] p;
    logic [6:0]    e;
    bit            ok;
    int            cyc;
    p = PAT_RST;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      p = rot_left(p);
      exp_q.push_back(p);
    end
    sb_on = 1'b1;
    reset = 1'b0;
    tick_wait(30, ok, cyc);
    checks++;
    if (!ok || cyc != 9) begin
      errors++; $display("FAIL first_tick: got %0d cycles (ok=%0b), required 9", cyc, ok);
    end
    for (int k = 0; k < 2; k++) begin
      tick_wait(30, ok, cyc);
      checks++;
      if (!ok || cyc != 10) begin
        errors++; $display("FAIL tick_period10: got %0d cycles (ok=%0b), required 10", cyc, ok);
      end
    end
    repeat (2) @(posedge clk); #1;
    sb_on = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scroll_drain: got %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (pattern_out !== 24'h000E00) begin
      errors++; $display("FAIL scroll_digit3: got %h, required 000e00", pattern_out);
    end
    for (int i = 0; i < N; i++) begin
      e = (i == 3) ? seg_of(7) : seg_of(0);
      checks++;
      if (hex_out[i*7 +: 7] !== e) begin
        errors++; $display("FAIL scroll_hex%0d: got %b, required %b", i, hex_out[i*7 +: 7], e);
      end
    end
  endtask

  task automatic test_speed_up();
    int exp_tab[4];
    bit ok;
    int cyc;
    exp_tab = '{7, 5, 3, 3};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); speed_up = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (div_limit !== 27'(exp_tab[k])) begin
        errors++; $display("FAIL speed_up%0d: got %0d, required %0d", k, div_limit, exp_tab[k]);
      end
      @(negedge clk); speed_up = 1'b0;
    end
    tick_wait(40, ok, cyc);
    for (int k = 0; k < 2; k++) begin
      tick_wait(20, ok, cyc);
      checks++;
      if (!ok || cyc != 4) begin
        errors++; $display("FAIL tick_period4: got %0d cycles (ok=%0b), required 4", cyc, ok);
      end
    end
  endtask

  task automatic test_early_wrap();
    do_reset();
    repeat (8) @(posedge clk); #1;
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL early_pre: got tick %b, required 0", tick);
    end
    @(negedge clk); speed_up = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (div_limit !== 27'd7) begin
      errors++; $display("FAIL early_limit: got %0d, required 7", div_limit);
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++; $display("FAIL early_wrap: got tick %b, required 1", tick);
    end
    @(negedge clk); speed_up = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL early_post: got tick %b, required 0", tick);
    end
  endtask

  task automatic test_speed_dn();
    int exp_tab[5];
    exp_tab = '{11, 13, 15, 15, 15};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); speed_dn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (div_limit !== 27'(exp_tab[k])) begin
        errors++; $display("FAIL speed_dn%0d: got %0d, required %0d", k, div_limit, exp_tab[k]);
      end
      @(negedge clk); speed_dn = 1'b0;
    end
    // Holding the button must give exactly one step.
    @(negedge clk); speed_up = 1'b1;
    repeat (5) @(posedge clk); #1;
    checks++;
    if (div_limit !== 27'd13) begin
      errors++; $display("FAIL hold_up: got %0d, required 13", div_limit);
    end
    @(negedge clk); speed_up = 1'b0;
    @(negedge clk); speed_up = 1'b1; speed_dn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (div_limit !== 27'd13) begin
      errors++; $display("FAIL both_edges: got %0d, required 13", div_limit);
    end
    @(negedge clk); speed_up = 1'b0; speed_dn = 1'b0;
  endtask

  task automatic test_direction();
    bit ok;
    int cyc;
    @(negedge clk); dir = 1'b1; run = 1'b1;
    do_reset();
    exp_q.push_back(24'hE00000);
    sb_on = 1'b1;
    tick_wait(30, ok, cyc);
    @(posedge clk); #1;
    checks++;
    if (!ok || pattern_out !== 24'hE00000) begin
      errors++; $display("FAIL dir_right_wrap: got %h (ok=%0b), required e00000", pattern_out, ok);
    end
    @(negedge clk); dir = 1'b0;
    exp_q.push_back(PAT_RST);
    tick_wait(30, ok, cyc);
    @(posedge clk); #1;
    checks++;
    if (!ok || pattern_out !== PAT_RST) begin
      errors++; $display("FAIL dir_left_back: got %h (ok=%0b), required %h", pattern_out, ok, PAT_RST);
    end
    sb_on = 1'b0;
    wait_drain(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL dir_drain: got %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_load_on_tick(output logic [PW-1:0] lp);
    bit ok;
    int cyc;
    for (int i = 0; i < N; i++) lp[i*W +: W] = W'((i + 1) % 8);
    exp_q.push_back(lp);
    @(negedge clk); sb_on = 1'b1;
    tick_wait(30, ok, cyc);
    @(negedge clk); load = 1'b1; load_pattern = lp;
    @(negedge clk); load = 1'b0;
    @(posedge clk); #1;
    sb_on = 1'b0;
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL load_tick_seen: got ok=%0b left=%0d, required ok=1 left=0", ok, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (pattern_out !== lp) begin
      errors++; $display("FAIL load_pattern: got %h, required %h", pattern_out, lp);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (hex_out[i*7 +: 7] !== seg_of((i + 1) % 8)) begin
        errors++;
        $display("FAIL load_hex%0d: got %b, required %b", i, hex_out[i*7 +: 7], seg_of((i + 1) % 8));
      end
    end
  endtask

  task automatic test_run_gate(input logic [PW-1:0] lp);
    bit ok;
    int cyc;
    @(negedge clk); run = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(lp);
    sb_on = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick_wait(30, ok, cyc);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL frozen_tick%0d: got no tick in 30 cycles, required a tick", k);
      end
    end
    @(posedge clk); #1;
    sb_on = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL frozen_drain: got %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (pattern_out !== lp) begin
      errors++; $display("FAIL frozen_pattern: got %h, required %h", pattern_out, lp);
    end
    @(negedge clk); run = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    @(negedge clk); speed_up = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (div_limit !== 27'd7) begin
      errors++; $display("FAIL mid_pre_limit: got %0d, required 7", div_limit);
    end
    @(negedge clk); speed_up = 1'b0;
    // Reset lands on a tick edge with run = 1: no rotation may leak through.
    tick_wait(30, ok, cyc);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pattern_out !== PAT_RST) begin
      errors++; $display("FAIL mid_reset_pattern: got %h, required %h", pattern_out, PAT_RST);
    end
    checks++;
    if (div_limit !== 27'd9) begin
      errors++; $display("FAIL mid_reset_limit: got %0d, required 9", div_limit);
    end
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL mid_reset_tick: got %b, required 0", tick);
    end
    @(negedge clk); reset = 1'b0;
    tick_wait(30, ok, cyc);
    checks++;
    if (!ok || cyc != 9) begin
      errors++; $display("FAIL mid_reset_count: got %0d cycles (ok=%0b), required 9", cyc, ok);
    end
  endtask

  initial begin
    logic [PW-1:0] lp;
    test_reset();
    test_scroll_left();
    test_speed_up();
    test_early_wrap();
    test_speed_dn();
    test_direction();
    test_load_on_tick(lp);
    test_run_gate(lp);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
